dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-port 32-bit data memory between the pipeline MEM stage (port 0) and the debug/loader port (port 1). Each port issues one-cycle read or write requests over a valid/ready handshake. The arbiter drives the memory's address, write-data and write-enable, and captures read data into a registered per-port response one cycle later. It sits between the MEM stage and the data memory, replacing the direct connection.

## Interface
- WIDTH, 32: data and address width.
- DEPTH, 100: memory depth in words; valid word addresses are 0..DEPTH-1.
- DataMemory_CLK  input  1  clock; shared with the data memory.
- DataMemory_RST  input  1  asynchronous, active-low reset.
- reqN_valid  input  1  port N (N=0,1) request present.
- reqN_ready  output  1  port N granted this cycle; combinational.
- reqN_we  input  1  1 = write, 0 = read.
- reqN_addr  input  WIDTH  word address.
- reqN_wdata  input  WIDTH  write data.
- rspN_valid  output  1  one-cycle response pulse.
- rspN_rdata  output  WIDTH  memory word at the address, sampled at the accept edge.
- rspN_err  output  1  address out of range; qualified by rspN_valid.
- mem_a  output  WIDTH  memory address.
- mem_wd  output  WIDTH  memory write data.
- mem_we  output  1  memory write enable.
- mem_rd  input  WIDTH  combinational memory read data.
- arb_stall_cnt  output  16  saturating count of cycles with an ungranted valid request.

## Operation
- Grant logic:
  - If exactly one port is valid, that port is granted.
  - If both ports are valid, the port selected by the priority pointer `prio` is granted (see Configuration).
  - At most one reqN_ready is high in any cycle.
  - reqN_ready is never high unless reqN_valid is high.
- Accepted transaction: reqN_valid & reqN_ready at a rising edge.
- Memory drive:
  - mem_a and mem_wd come from the granted port.
  - When nothing is granted, mem_a and mem_wd carry port 0's values.
  - mem_we = granted & reqN_we & (reqN_addr < DEPTH). mem_we is 0 when nothing is granted.
- Out-of-range access (addr >= DEPTH):
  - No memory write.
  - Response has rspN_err=1 and rspN_rdata=0.
- Read-before-write: a write response returns the old memory contents, because mem_rd is sampled at the same edge that performs the write.
- Stall counter: arb_stall_cnt increments by 1 for each cycle in which some reqN_valid=1 and reqN_ready=0. It saturates at 0xFFFF.
  - When both ports are valid, only one is ungranted, so the counter increments by 1, not 2.
- A requester holds valid, we, addr and wdata stable until it is granted. Port inputs may change freely after acceptance.

## Timing
- Grant is combinational. The memory write occurs at the accept edge.
- Response latency is 1 cycle: rspN_valid is high exactly during the cycle after acceptance, then low unless accepted again.
- Back-to-back accepts on one port produce back-to-back rspN_valid pulses.
- rspN_rdata and rspN_err hold their last values until the next response on that port.
- Reset values:
  - rsp0_valid = rsp1_valid = 0.
  - rsp0_rdata = rsp1_rdata = 0.
  - rsp0_err = rsp1_err = 0.
  - arb_stall_cnt = 0.
  - prio = port 0.
- Reset mid-transaction: pending responses are discarded, with no rspN_valid pulse after reset release. The memory is cleared by the same reset.
- First cycle after reset release: normal arbitration with prio = port 0.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration.
  - After any grant to port k, prio moves to the other port.
  - A continuously requesting port waits at most 1 cycle.
- DMEM_ARB_RR_EN undefined: fixed priority.
  - Port 0 always wins a conflict and the prio register is absent.
  - Port 1 can starve indefinitely; arb_stall_cnt counts those cycles.

## Test plan
- Single read:
  - Stimulus: write 0xDEADBEEF to addr 5 via port 0, then read addr 5 via port 1.
  - Response: each accepted in one cycle; rsp1_valid=1 one cycle after the read with rsp1_rdata=0xDEADBEEF and rsp1_err=0.
- Conflict, round-robin (RR_EN defined):
  - Stimulus: both ports request reads continuously for 6 cycles.
  - Response: grants alternate 0,1,0,1,0,1; arb_stall_cnt=6.
- Conflict, fixed priority (RR_EN undefined):
  - Stimulus: same as the round-robin case.
  - Response: port 0 is granted all 6 cycles, port 1 never; arb_stall_cnt=6.
- Out of range:
  - Stimulus: port 1 writes 0x1234 to addr 100.
  - Response: mem_we=0; rsp1_err=1 and rsp1_rdata=0; a later read of addr 0..99 is unchanged.
- Read-before-write:
  - Stimulus: addr 7 holds 0x11; port 0 writes 0x22 to addr 7.
  - Response: rsp0_rdata=0x11; a following read returns 0x22.
- Reset mid-operation:
  - Stimulus: assert DataMemory_RST low in the cycle after an accepted read.
  - Response: rsp0_valid=0 immediately, arb_stall_cnt=0, all memory reads 0 after reset release.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for both dmem_arbiter ports.
// master = requesters (MEM stage, loader), slave = arbiter.
interface dmem_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic             req0_we;
  logic [WIDTH-1:0] req0_addr;
  logic [WIDTH-1:0] req0_wdata;
  logic             rsp0_valid;
  logic [WIDTH-1:0] rsp0_rdata;
  logic             rsp0_err;

  logic             req1_valid;
  logic             req1_ready;
  logic             req1_we;
  logic [WIDTH-1:0] req1_addr;
  logic [WIDTH-1:0] req1_wdata;
  logic             rsp1_valid;
  logic [WIDTH-1:0] rsp1_rdata;
  logic             rsp1_err;

  modport master (
    output req0_valid, req0_we,
    output req0_addr, req0_wdata,
    input  req0_ready,
    input  rsp0_valid, rsp0_rdata, rsp0_err,
    output req1_valid, req1_we,
    output req1_addr, req1_wdata,
    input  req1_ready,
    input  rsp1_valid, rsp1_rdata, rsp1_err
  );

  modport slave (
    input  req0_valid, req0_we,
    input  req0_addr, req0_wdata,
    output req0_ready,
    output rsp0_valid, rsp0_rdata, rsp0_err,
    input  req1_valid, req1_we,
    input  req1_addr, req1_wdata,
    output req1_ready,
    output rsp1_valid, rsp1_rdata, rsp1_err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
// Port 0 = MEM stage, port 1 = debug/loader; both on bus (slave).
// Ports: DataMemory_CLK, DataMemory_RST (async, active-low),
//   bus: reqN_* in / reqN_ready, rspN_* out,
//   mem_a/mem_wd/mem_we out, mem_rd in,
//   arb_stall_cnt: saturating count of stalled cycles.
// Option: DMEM_ARB_RR_EN selects round-robin, else fixed priority.
module dmem_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 100
) (
  input  logic             DataMemory_CLK,
  input  logic             DataMemory_RST,
  dmem_arbiter_if.slave    bus,
  output logic [WIDTH-1:0] mem_a,
  output logic [WIDTH-1:0] mem_wd,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_rd,
  output logic [15:0]      arb_stall_cnt
);

  localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);

  logic gnt0;
  logic gnt1;
  logic ok0;
  logic ok1;
  logic stall;
  logic [15:0] stall_q;

`ifdef DMEM_ARB_RR_EN
  // prio = 0: port 0 wins a conflict; 1: port 1 wins
  logic prio;

  assign gnt0 = bus.req0_valid & (~bus.req1_valid | ~prio);
  assign gnt1 = bus.req1_valid & (~bus.req0_valid | prio);

  always_ff @(posedge DataMemory_CLK or negedge DataMemory_RST) begin
    if (!DataMemory_RST) begin
      prio <= 1'b0;
    end else if (gnt0) begin
      prio <= 1'b1;
    end else if (gnt1) begin
      prio <= 1'b0;
    end
  end
`else
  assign gnt0 = bus.req0_valid;
  assign gnt1 = bus.req1_valid & ~bus.req0_valid;
`endif

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  assign ok0 = bus.req0_addr < DEPTH_W;
  assign ok1 = bus.req1_addr < DEPTH_W;

  // Port 0 owns the bus when idle so the address is never undriven
  assign mem_a  = gnt1 ? bus.req1_addr  : bus.req0_addr;
  assign mem_wd = gnt1 ? bus.req1_wdata : bus.req0_wdata;
  assign mem_we = (gnt0 & bus.req0_we & ok0)
                | (gnt1 & bus.req1_we & ok1);

  // At most one port can be ungranted, so this is a 0/1 step
  assign stall = (bus.req0_valid & ~gnt0)
               | (bus.req1_valid & ~gnt1);

  assign arb_stall_cnt = stall_q;

  // mem_rd is sampled at the write edge: writes return old data
  always_ff @(posedge DataMemory_CLK or negedge DataMemory_RST) begin
    if (!DataMemory_RST) begin
      bus.rsp0_valid <= 1'b0;
      bus.rsp0_rdata <= '0;
      bus.rsp0_err   <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      bus.rsp1_rdata <= '0;
      bus.rsp1_err   <= 1'b0;
      stall_q        <= '0;
    end else begin
      bus.rsp0_valid <= gnt0;
      bus.rsp1_valid <= gnt1;
      if (gnt0) begin
        bus.rsp0_rdata <= ok0 ? mem_rd : '0;
        bus.rsp0_err   <= ~ok0;
      end
      if (gnt1) begin
        bus.rsp1_rdata <= ok1 ? mem_rd : '0;
        bus.rsp1_err   <= ~ok1;
      end
      if (stall && stall_q != 16'hFFFF) begin
        stall_q <= stall_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter.
// Memory is modelled here; a golden array predicts responses.
module tb_dmem_arbiter;

  localparam int W = 32;
  localparam int D = 100;

  typedef struct {
    logic        v;
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
  } req_t;

  typedef struct {
    int unsigned cyc;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;
  logic [15:0] stall_cnt;

  dmem_arbiter_if #(.WIDTH(W)) bus ();

  dmem_arbiter #(.WIDTH(W), .DEPTH(D)) dut (
    .DataMemory_CLK (clk),
    .DataMemory_RST (rst),
    .bus            (bus),
    .mem_a          (mem_a),
    .mem_wd         (mem_wd),
    .mem_we         (mem_we),
    .mem_rd         (mem_rd),
    .arb_stall_cnt  (stall_cnt)
  );

  // data memory environment (cleared by the same reset)
  logic [31:0] ram [D];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < D; i++) ram[i] <= '0;
    end else if (mem_we && mem_a < 32'(D)) begin
      ram[mem_a[6:0]] <= mem_wd;
    end
  end

  assign mem_rd = (mem_a < 32'(D)) ? ram[mem_a[6:0]] : '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] gold [D];
  int          last_win;
  int          stall_m;
  exp_t        q0[$];
  exp_t        q1[$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) gold[i] = '0;
    last_win = 1;
    stall_m  = 0;
    q0.delete();
    q1.delete();
  endtask

  function automatic exp_t accept(input req_t r);
    exp_t e;
    e.cyc = cyc + 1;
    e.err = (r.a >= 32'(D));
    e.rd  = e.err ? 32'h0 : gold[r.a];
    if (r.we && !e.err) gold[r.a] = r.d;
    return e;
  endfunction

  // monitors: pop on response, flag missing or unexpected pulses
  always @(negedge clk) begin
    if (q0.size() > 0 && q0[0].cyc == cyc) begin
      check("rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
      check("rsp0_rdata", bus.rsp0_rdata, q0[0].rd);
      check("rsp0_err", 32'(bus.rsp0_err), 32'(q0[0].err));
      void'(q0.pop_front());
    end else if (bus.rsp0_valid) begin
      check("rsp0_unexpected", 32'(bus.rsp0_valid), 32'd0);
    end
  end

  always @(negedge clk) begin
    if (q1.size() > 0 && q1[0].cyc == cyc) begin
      check("rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
      check("rsp1_rdata", bus.rsp1_rdata, q1[0].rd);
      check("rsp1_err", 32'(bus.rsp1_err), 32'(q1[0].err));
      void'(q1.pop_front());
    end else if (bus.rsp1_valid) begin
      check("rsp1_unexpected", 32'(bus.rsp1_valid), 32'd0);
    end
  end

  // one bus cycle: drive, predict grant, check, advance
  task automatic cycle(input req_t r0, input req_t r1,
                       output logic g0, output logic g1);
    logic        we_e;
    logic [31:0] a_e;
    @(negedge clk);
    bus.req0_valid = r0.v;
    bus.req0_we    = r0.we;
    bus.req0_addr  = r0.a;
    bus.req0_wdata = r0.d;
    bus.req1_valid = r1.v;
    bus.req1_we    = r1.we;
    bus.req1_addr  = r1.a;
    bus.req1_wdata = r1.d;
    #1;
    if (r0.v && r1.v) begin
`ifdef DMEM_ARB_RR_EN
      g0 = (last_win == 1);
`else
      g0 = 1'b1;
`endif
      g1 = !g0;
    end else begin
      g0 = r0.v;
      g1 = r1.v;
    end
    check("req0_ready", 32'(bus.req0_ready), 32'(g0));
    check("req1_ready", 32'(bus.req1_ready), 32'(g1));
    we_e = 1'b0;
    a_e  = r0.a;
    if (g0) begin
      we_e = r0.we && r0.a < 32'(D);
      q0.push_back(accept(r0));
      last_win = 0;
    end
    if (g1) begin
      we_e = r1.we && r1.a < 32'(D);
      a_e  = r1.a;
      q1.push_back(accept(r1));
      last_win = 1;
    end
    check("mem_we", 32'(mem_we), 32'(we_e));
    check("mem_a", mem_a, a_e);
    if ((r0.v && !g0) || (r1.v && !g1)) begin
      if (stall_m < 16'hFFFF) stall_m++;
    end
    @(posedge clk);
    #1;
    check("stall_cnt", 32'(stall_cnt), 32'(stall_m));
  endtask

  function automatic req_t mk(input logic v, input logic we,
                              input int a, input logic [31:0] d);
    req_t r;
    r.v  = v;
    r.we = we;
    r.a  = 32'(a);
    r.d  = d;
    return r;
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    r.v  = 1'b1;
    r.we = 1'($urandom_range(0, 1));
    r.a  = 32'($urandom_range(0, D + 9));
    r.d  = $urandom;
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    req_t idle;
    req_t p0;
    req_t p1;
    logic g0;
    logic g1;
    int   n1;
    int   s0;

    idle = mk(1'b0, 1'b0, 0, 32'h0);
    bus.req0_valid = 1'b0;
    bus.req0_we    = 1'b0;
    bus.req0_addr  = '0;
    bus.req0_wdata = '0;
    bus.req1_valid = 1'b0;
    bus.req1_we    = 1'b0;
    bus.req1_addr  = '0;
    bus.req1_wdata = '0;
    model_reset();
    rst = 1'b0;
    #23;
    check("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    check("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
    check("rst_rsp0_rdata", bus.rsp0_rdata, 32'd0);
    check("rst_rsp1_err", 32'(bus.rsp1_err), 32'd0);
    check("rst_stall", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // conflict: both ports read continuously for 6 cycles
    n1 = 0;
    s0 = stall_m;
    for (int i = 0; i < 6; i++) begin
      cycle(mk(1'b1, 1'b0, 1, 32'h0), mk(1'b1, 1'b0, 2, 32'h0),
            g0, g1);
      if (g1) n1++;
    end
`ifdef DMEM_ARB_RR_EN
    check("conflict_p1_grants", 32'(n1), 32'd3);
`else
    check("conflict_p1_grants", 32'(n1), 32'd0);
`endif
    check("conflict_stall", 32'(stall_cnt), 32'(s0 + 6));

    // single write then read
    cycle(mk(1'b1, 1'b1, 5, 32'hDEADBEEF), idle, g0, g1);
    cycle(idle, mk(1'b1, 1'b0, 5, 32'h0), g0, g1);
    check("single_rd_valid", 32'(bus.rsp1_valid), 32'd1);
    check("single_rd_data", bus.rsp1_rdata, 32'hDEADBEEF);
    check("single_rd_err", 32'(bus.rsp1_err), 32'd0);

    // out of range write
    cycle(idle, mk(1'b1, 1'b1, D, 32'h1234), g0, g1);
    check("oor_err", 32'(bus.rsp1_err), 32'd1);
    check("oor_rdata", bus.rsp1_rdata, 32'd0);

    // read-before-write
    cycle(mk(1'b1, 1'b1, 7, 32'h11), idle, g0, g1);
    cycle(mk(1'b1, 1'b1, 7, 32'h22), idle, g0, g1);
    check("rbw_old", bus.rsp0_rdata, 32'h11);
    cycle(mk(1'b1, 1'b0, 7, 32'h0), idle, g0, g1);
    check("rbw_new", bus.rsp0_rdata, 32'h22);

    // random traffic; requests held until granted
    p0 = idle;
    p1 = idle;
    for (int i = 0; i < 300; i++) begin
      if (!p0.v && $urandom_range(0, 3) != 0) p0 = rnd_req();
      if (!p1.v && $urandom_range(0, 3) != 0) p1 = rnd_req();
      cycle(p0, p1, g0, g1);
      if (g0) p0.v = 1'b0;
      if (g1) p1.v = 1'b0;
    end
    for (int i = 0; i < 4 && (p0.v || p1.v); i++) begin
      cycle(p0, p1, g0, g1);
      if (g0) p0.v = 1'b0;
      if (g1) p1.v = 1'b0;
    end

    // sweep all words against the golden image
    for (int a = 0; a < D; a++) begin
      cycle(idle, mk(1'b1, 1'b0, a, 32'h0), g0, g1);
    end

    // reset right after an accepted read
    cycle(mk(1'b1, 1'b1, 9, 32'hCAFE0009), idle, g0, g1);
    cycle(mk(1'b1, 1'b0, 9, 32'h0), idle, g0, g1);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check("midrst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    check("midrst_stall", 32'(stall_cnt), 32'd0);
    check("midrst_rdata", bus.rsp0_rdata, 32'd0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    for (int a = 0; a < D; a++) begin
      cycle(mk(1'b1, 1'b0, a, 32'h0), idle, g0, g1);
    end
    cycle(idle, idle, g0, g1);
    cycle(idle, idle, g0, g1);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
